// File: rtl/rs_int_scheduler.sv
// Occupancy and issue scheduler for one integer reservation station.
// Tracks a FREE/WAIT/ISSUED/DONE state per line and drives the line write/commit enables.
module rs_int_scheduler #(
  parameter int LINE_NUM        = 8,
  parameter int LINE_ADDR_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       cdb_bus_en,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  output logic [LINE_ADDR_WIDTH-1:0] disp_line,
  output logic [LINE_NUM-1:0]        line_write_en,
  input  logic [LINE_NUM-1:0]        line_operand_ready,
  output logic                       issue_valid,
  output logic [LINE_ADDR_WIDTH-1:0] issue_line,
  input  logic                       issue_ready,
  input  logic                       fu_done_valid,
  input  logic [LINE_ADDR_WIDTH-1:0] fu_done_line,
  output logic                       fu_done_ready,
  output logic [LINE_NUM-1:0]        line_commit_en,
  input  logic                       retire_valid,
  input  logic [LINE_ADDR_WIDTH-1:0] retire_line,
  output logic [LINE_ADDR_WIDTH:0]   free_count,
  output logic                       err
);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ISSUED = 2'd2,
    ST_DONE   = 2'd3
  } line_state_e;

  logic [LINE_NUM-1:0]        is_free;
  logic [LINE_NUM-1:0]        is_wait;
  logic [LINE_NUM-1:0]        is_issued;
  logic [LINE_NUM-1:0]        is_done;
  logic [LINE_NUM-1:0]        free_d;
  logic [LINE_NUM-1:0]        issue_cand;
  logic [LINE_NUM-1:0]        issue_sel;
  logic [LINE_NUM-1:0]        retire_sel;

  logic [LINE_ADDR_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [LINE_ADDR_WIDTH-1:0] pend_line_q, pend_line_d;
  logic                       pend_valid_q, pend_valid_d;
  logic                       err_q, err_d;
  logic [LINE_ADDR_WIDTH:0]   free_count_q, free_count_d;

  logic                       disp_fire;
  logic                       issue_fire;
  logic                       done_take;
  logic                       done_ok;
  logic                       done_bad;
  logic                       commit_fire;
  logic                       retire_ok;
  logic                       retire_bad;

  // Dispatch: lowest-index FREE line; a CDB broadcast blocks the write port.
  always_comb begin
    disp_line = '0;
    for (int i = LINE_NUM - 1; i >= 0; i--) begin
      if (is_free[i]) disp_line = LINE_ADDR_WIDTH'(i);
    end
  end

  assign disp_ready = (|is_free) & ~cdb_bus_en;
  assign disp_fire  = disp_valid & disp_ready;

  // Issue: round-robin search upward from rr_ptr_q, wrapping naturally.
  assign issue_cand = is_wait & line_operand_ready;

  always_comb begin
    logic                       found;
    logic [LINE_ADDR_WIDTH-1:0] idx;
    found      = 1'b0;
    idx        = '0;
    issue_line = '0;
    for (int k = 0; k < LINE_NUM; k++) begin
      idx = rr_ptr_q + LINE_ADDR_WIDTH'(k);
      if (!found && issue_cand[idx]) begin
        issue_line = idx;
        found      = 1'b1;
      end
    end
  end

  assign issue_valid = |issue_cand;
  assign issue_fire  = issue_valid & issue_ready;

  // Completion and commit: a single pending slot, held while the CDB is busy.
  assign fu_done_ready = ~pend_valid_q;
  assign done_take     = fu_done_valid & fu_done_ready;
  assign done_ok       = done_take & is_issued[fu_done_line];
  assign done_bad      = done_take & ~is_issued[fu_done_line];
  assign commit_fire   = pend_valid_q & ~cdb_bus_en;

  assign retire_ok  = retire_valid & is_done[retire_line];
  assign retire_bad = retire_valid & ~is_done[retire_line];

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    pend_valid_d = pend_valid_q;
    pend_line_d  = pend_line_q;
    err_d        = err_q;
    if (flush) begin
      rr_ptr_d     = '0;
      pend_valid_d = 1'b0;
      pend_line_d  = '0;
    end else begin
      if (issue_fire) rr_ptr_d = issue_line + LINE_ADDR_WIDTH'(1);
      if (commit_fire) pend_valid_d = 1'b0;
      if (done_ok) begin
        pend_valid_d = 1'b1;
        pend_line_d  = fu_done_line;
      end
      if (done_bad || retire_bad) err_d = 1'b1;
    end
  end

  // Counts the post-edge state, so free_count tracks the lines it describes.
  always_comb begin
    free_count_d = '0;
    for (int i = 0; i < LINE_NUM; i++) begin
      free_count_d = free_count_d + (LINE_ADDR_WIDTH + 1)'(free_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_line_q  <= '0;
      err_q        <= 1'b0;
      free_count_q <= (LINE_ADDR_WIDTH + 1)'(LINE_NUM);
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      pend_valid_q <= pend_valid_d;
      pend_line_q  <= pend_line_d;
      err_q        <= err_d;
      free_count_q <= free_count_d;
    end
  end

  assign free_count = free_count_q;
  assign err        = err_q;

  // Per-line state machines; events target distinct states, so at most one applies per line.
  for (genvar gi = 0; gi < LINE_NUM; gi++) begin : g_line
    line_state_e st_q, st_d;

    assign line_write_en[gi]  = disp_fire & (disp_line == LINE_ADDR_WIDTH'(gi));
    assign issue_sel[gi]      = issue_fire & (issue_line == LINE_ADDR_WIDTH'(gi));
    assign line_commit_en[gi] = commit_fire & (pend_line_q == LINE_ADDR_WIDTH'(gi));
    assign retire_sel[gi]     = retire_ok & (retire_line == LINE_ADDR_WIDTH'(gi));

    always_comb begin
      st_d = st_q;
      if (flush) begin
        st_d = ST_FREE;
      end else begin
        if (line_write_en[gi])  st_d = ST_WAIT;
        if (issue_sel[gi])      st_d = ST_ISSUED;
        if (line_commit_en[gi]) st_d = ST_DONE;
        if (retire_sel[gi])     st_d = ST_FREE;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) st_q <= ST_FREE;
      else     st_q <= st_d;
    end

    assign is_free[gi]   = (st_q == ST_FREE);
    assign is_wait[gi]   = (st_q == ST_WAIT);
    assign is_issued[gi] = (st_q == ST_ISSUED);
    assign is_done[gi]   = (st_q == ST_DONE);
    assign free_d[gi]    = (st_d == ST_FREE);
  end

endmodule

// File: tb/tb_rs_int_scheduler.sv
// Bench for rs_int_scheduler (4 lines): directed scenarios, then random traffic,
// every cycle compared against a line-state reference model.
module tb_rs_int_scheduler;
  localparam int N  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst, flush, cdb_bus_en, disp_valid, issue_ready;
  logic          fu_done_valid, retire_valid;
  logic [AW-1:0] fu_done_line, retire_line;
  logic [N-1:0]  line_operand_ready;
  logic          disp_ready, issue_valid, fu_done_ready, err;
  logic [AW-1:0] disp_line, issue_line;
  logic [N-1:0]  line_write_en, line_commit_en;
  logic [AW:0]   free_count;

  rs_int_scheduler #(.LINE_NUM(N), .LINE_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .cdb_bus_en(cdb_bus_en),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_line(disp_line),
    .line_write_en(line_write_en), .line_operand_ready(line_operand_ready),
    .issue_valid(issue_valid), .issue_line(issue_line), .issue_ready(issue_ready),
    .fu_done_valid(fu_done_valid), .fu_done_line(fu_done_line),
    .fu_done_ready(fu_done_ready), .line_commit_en(line_commit_en),
    .retire_valid(retire_valid), .retire_line(retire_line),
    .free_count(free_count), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model: 0=FREE 1=WAIT 2=ISSUED 3=DONE
  int m_st[N];
  int m_rr, m_pline, m_fcnt;
  bit m_pend, m_err, m_valid;

  function automatic int lowest_free();
    for (int i = 0; i < N; i++) if (m_st[i] == 0) return i;
    return -1;
  endfunction

  function automatic int rr_pick();
    for (int k = 0; k < N; k++) begin
      int idx = (m_rr + k) % N;
      if (m_st[idx] == 1 && line_operand_ready[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic compare_model();
    int lf, iss;
    bit dr;
    if (!m_valid) return;
    lf  = lowest_free();
    iss = rr_pick();
    dr  = !cdb_bus_en && lf >= 0;
    check_eq("disp_ready", disp_ready, dr);
    check_eq("disp_line", disp_line, (lf < 0) ? 0 : lf);
    check_eq("line_write_en", line_write_en, (disp_valid && dr) ? (1 << lf) : 0);
    check_eq("issue_valid", issue_valid, iss >= 0);
    if (iss >= 0) check_eq("issue_line", issue_line, iss);
    check_eq("fu_done_ready", fu_done_ready, !m_pend);
    check_eq("line_commit_en", line_commit_en, (m_pend && !cdb_bus_en) ? (1 << m_pline) : 0);
    check_eq("free_count", free_count, m_fcnt);
    check_eq("err", err, m_err);
  endtask

  task automatic model_step();
    int nst[N];
    int lf, iss;
    bit old_pend;
    if (rst) begin
      foreach (m_st[i]) m_st[i] = 0;
      m_rr = 0; m_pend = 0; m_pline = 0; m_err = 0; m_valid = 1;
    end else if (flush) begin
      foreach (m_st[i]) m_st[i] = 0;
      m_rr = 0; m_pend = 0; m_pline = 0;
    end else begin
      nst      = m_st;
      lf       = lowest_free();
      iss      = rr_pick();
      old_pend = m_pend;
      if (disp_valid && !cdb_bus_en && lf >= 0) nst[lf] = 1;
      if (iss >= 0 && issue_ready) begin
        nst[iss] = 2;
        m_rr = (iss + 1) % N;
      end
      if (old_pend && !cdb_bus_en) begin
        nst[m_pline] = 3;
        m_pend = 0;
      end
      if (fu_done_valid && !old_pend) begin
        if (m_st[fu_done_line] == 2) begin
          m_pend = 1;
          m_pline = int'(fu_done_line);
        end else m_err = 1;
      end
      if (retire_valid) begin
        if (m_st[retire_line] == 3) nst[retire_line] = 0;
        else m_err = 1;
      end
      m_st = nst;
    end
    m_fcnt = 0;
    foreach (m_st[i]) if (m_st[i] == 0) m_fcnt++;
  endtask

  task automatic settle();
    #1;
  endtask

  // Compare, clock, advance model, return to the falling edge for the next drive.
  task automatic cycle();
    compare_model();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; flush = 0; cdb_bus_en = 0; disp_valid = 0; issue_ready = 0;
    fu_done_valid = 0; fu_done_line = '0; retire_valid = 0; retire_line = '0;
    line_operand_ready = '0;
  endtask

  task automatic complete_retire(input int l);
    fu_done_valid = 1; fu_done_line = AW'(l);
    settle(); cycle();
    fu_done_valid = 0;
    settle();
    check_eq("commit_onehot", line_commit_en, 1 << l);
    cycle();
    retire_valid = 1; retire_line = AW'(l);
    settle(); cycle();
    retire_valid = 0;
  endtask

  initial begin
    m_valid = 0;
    idle();
    rst = 1;
    @(negedge clk);
    settle(); cycle();
    settle(); cycle();
    rst = 0;

    settle();
    check_eq("rst_free_count", free_count, N);
    check_eq("rst_disp_ready", disp_ready, 1);
    check_eq("rst_issue_valid", issue_valid, 0);
    check_eq("rst_err", err, 0);
    cycle();

    // fill
    disp_valid = 1;
    for (int i = 0; i < N; i++) begin
      settle();
      check_eq("fill_line", disp_line, i);
      check_eq("fill_wen", line_write_en, 1 << i);
      check_eq("fill_count", free_count, N - i);
      cycle();
    end
    disp_valid = 0;
    settle();
    check_eq("full_ready", disp_ready, 0);
    check_eq("full_count", free_count, 0);
    cycle();

    // round robin 0..3
    line_operand_ready = '1; issue_ready = 1;
    for (int i = 0; i < N; i++) begin
      settle();
      check_eq("rr_order", issue_line, i);
      cycle();
    end
    line_operand_ready = '0; issue_ready = 0;

    // wrap: line 3 then line 0
    complete_retire(3);
    disp_valid = 1; settle(); check_eq("redisp3", disp_line, 3); cycle(); disp_valid = 0;
    line_operand_ready = 4'b1000; issue_ready = 1;
    settle(); check_eq("wrap_issue3", issue_line, 3); cycle();
    line_operand_ready = '0; issue_ready = 0;
    complete_retire(0);
    disp_valid = 1; settle(); check_eq("redisp0", disp_line, 0); cycle(); disp_valid = 0;
    line_operand_ready = 4'b0001; issue_ready = 1;
    settle(); check_eq("wrap_issue0", issue_line, 0); cycle();
    line_operand_ready = '0; issue_ready = 0;

    // CDB blocking of commit for line 2
    fu_done_valid = 1; fu_done_line = 2; settle(); cycle(); fu_done_valid = 0;
    cdb_bus_en = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("cdb_commit", line_commit_en, 0);
      check_eq("cdb_fdr", fu_done_ready, 0);
      check_eq("cdb_disp_ready", disp_ready, 0);
      cycle();
    end
    cdb_bus_en = 0;
    settle(); check_eq("cdb_release", line_commit_en, 4'b0100); cycle();

    // retire + dispatch when full
    fu_done_valid = 1; fu_done_line = 1; settle(); cycle(); fu_done_valid = 0;
    settle(); cycle();
    retire_valid = 1; retire_line = 1; disp_valid = 1;
    settle(); check_eq("full_retire_wen", line_write_en, 0); cycle();
    retire_valid = 0;
    settle();
    check_eq("post_retire_line", disp_line, 1);
    check_eq("post_retire_wen", line_write_en, 4'b0010);
    cycle();
    disp_valid = 0;

    // protocol errors
    fu_done_valid = 1; fu_done_line = 1; settle(); cycle(); fu_done_valid = 0;
    line_operand_ready = 4'b0010;
    settle();
    check_eq("err_set", err, 1);
    check_eq("err_no_pend", fu_done_ready, 1);
    check_eq("err_line_wait", issue_line, 1);
    cycle();
    retire_valid = 1; retire_line = 2; settle(); cycle();
    settle(); cycle();
    retire_valid = 0;
    settle(); check_eq("err_sticky", err, 1); cycle();

    // flush with pending commit
    fu_done_valid = 1; fu_done_line = 0; settle(); cycle(); fu_done_valid = 0;
    flush = 1; settle(); cycle(); flush = 0;
    settle();
    check_eq("flush_count", free_count, N);
    check_eq("flush_fdr", fu_done_ready, 1);
    check_eq("flush_issue", issue_valid, 0);
    check_eq("flush_err_held", err, 1);
    cycle();

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      int q[$];
      rst                = ($urandom_range(0, 299) == 0);
      flush              = ($urandom_range(0, 59) == 0);
      cdb_bus_en         = ($urandom_range(0, 3) == 0);
      disp_valid         = ($urandom_range(0, 1) == 1);
      issue_ready        = ($urandom_range(0, 9) < 7);
      line_operand_ready = N'($urandom);
      q.delete();
      foreach (m_st[i]) if (m_st[i] == 2) q.push_back(i);
      fu_done_valid = ($urandom_range(0, 9) < 4);
      if (q.size() > 0 && $urandom_range(0, 19) != 0)
        fu_done_line = AW'(q[$urandom_range(0, q.size() - 1)]);
      else
        fu_done_line = AW'($urandom);
      q.delete();
      foreach (m_st[i]) if (m_st[i] == 3) q.push_back(i);
      retire_valid = ($urandom_range(0, 9) < 3);
      if (q.size() > 0 && $urandom_range(0, 19) != 0)
        retire_line = AW'(q[$urandom_range(0, q.size() - 1)]);
      else
        retire_line = AW'($urandom);
      settle();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
